mem_lane_sequencer: RTL and testbench
=====================================

Name: mem_lane_sequencer

Overview:
Parametrised successor to the core-shared memory controller. It serialises per-core (lane) load and store requests from N_CORES SIMT lanes onto one single-port memory, servicing enabled lanes in ascending index order. Adds configurable data/address widths, programmable memory read latency, per-lane read-valid flags and a one-cycle completion pulse. Sits between the lane register files and the shared data memory.

Parameters:
N_CORES, 4, number of lanes; >=1.
ADDR_W, 16, memory address width.
DATA_W, 16, data width.
RD_LAT, 1, memory read latency in cycles (0..7); 0 = combinational read.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
mread  in  1  start read of all enabled lanes (sampled only when idle)
mwrite  in  1  start write of all enabled lanes (sampled only when idle)
en  in  N_CORES  lane enable mask
addr  in  N_CORES*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W]
data  in  N_CORES*DATA_W  lane i store data, same packing
q  out  N_CORES*DATA_W  lane i load result, registered
q_valid  out  N_CORES  lane i load result captured this operation
mready  out  1  1 = idle, accepts start
done  out  1  one-cycle pulse when an operation completes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_rden  out  1  memory read enable
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE; mready=1; done=0; q=0; q_valid=0; mem_addr=0; mem_wdata=0; mem_wren=0; mem_rden=0; latched mask/op cleared. Aborted op produces no done.
- States: IDLE, ACCESS, WAIT, FINISH.
- IDLE: mready=1. Start = (mread|mwrite) at an edge. mwrite has priority if both high. At start edge: latch en into pending mask, latch op, clear q_valid to 0.
  - Pending mask 0: go FINISH; no memory access.
  - Else: current lane = lowest set bit; go ACCESS.
- ACCESS (1 cycle): mready=0; mem_addr=addr[lane]. Write: mem_wren=1, mem_wdata=data[lane]; clear lane bit; next lane = lowest remaining bit, stay ACCESS, or FINISH if none. Read: mem_rden=1; RD_LAT=0 -> capture mem_rdata into q[lane] and set q_valid[lane] at end of this cycle, advance as for write; RD_LAT>0 -> go WAIT.
- WAIT: mem_addr held, mem_rden=0, mem_wren=0; counts RD_LAT cycles; in the last WAIT cycle capture mem_rdata into q[lane], set q_valid[lane], clear lane bit, advance to next ACCESS or FINISH.
- FINISH (1 cycle): mready=1, done=1; next IDLE. Start in FINISH is accepted exactly as in IDLE.
- mread/mwrite while mready=0 ignored (not queued).
- en is sampled only at start; addr/data are sampled live in each lane's ACCESS cycle; cores hold them stable while mready=0.
- Latency: start at edge E0 -> mready=0 from cycle 1. K enabled lanes: write busy K cycles; read busy K*(1+RD_LAT) cycles; done in next cycle. Empty mask: done in cycle 1, mready never drops.
- q[i] of non-enabled lanes retains its previous value; q_valid[i]=0.
- mem_wren and mem_rden never both 1; both 0 outside ACCESS.
- Lane index counter width = max(1,$clog2(N_CORES)); no wrap-around, scan ends at lane N_CORES-1.

Test Plan:
- N_CORES=4, RD_LAT=1, mem[0x10+i]=0xA0+i, addr[i]=0x10+i, en=4'b1011, mread pulse -> mem_addr 0x10,0x11,0x13; mready low 6 cycles; done pulse cycle 7; q={0xA3,old,0xA1,0xA0}; q_valid=4'b1011.
- en=4'b0101, data[i]=0x5500+i, mwrite pulse -> mem_wren high 2 cycles at addr 0x10 then 0x12 with data 0x5500, 0x5502; done after 2 busy cycles; readback confirms.
- en=0, mread -> no mem_rden/mem_wren, mready stays 1, done pulse cycle 1.
- mread and mwrite together, en=4'b0001 -> write performed (mem_wren=1), no read.
- Read in progress on lane 1, assert reset in WAIT -> mready=1, q=0, q_valid=0, done never pulses; new mread after release completes normally.
- mwrite pulsed while busy on a read, then RD_LAT=0 build with en=4'b1111 -> busy op unaffected, no extra write; RD_LAT=0 read finishes in 4 cycles.

Source files
------------

// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer
// Serialises per-lane load/store requests from N_CORES SIMT lanes onto a
// single-port data memory. Enabled lanes are serviced in ascending index
// order, one memory access per lane, with a programmable read latency.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-high reset
//   mread      start a read of every enabled lane
//   mwrite     start a write of every enabled lane (wins over mread)
//   en         lane enable mask, sampled only at start
//   addr       packed lane addresses, lane i at [i*ADDR_W +: ADDR_W]
//   data       packed lane store data, lane i at [i*DATA_W +: DATA_W]
//   q          packed registered load results
//   q_valid    lane i load result captured during the current/last operation
//   mready     1 = idle, a start request is accepted
//   done       one-cycle pulse when an operation completes
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_wren   memory write enable
//   mem_rden   memory read enable
//   mem_rdata  memory read data, valid RD_LAT cycles after mem_rden
//   dbg_state  current sequencer state (IDLE=0, ACCESS=1, WAIT=2, FINISH=3)
//
// Handshake: a start (mread|mwrite high at a rising edge) is taken only while
// mready=1 (IDLE or FINISH). While mready=0 both request lines are ignored and
// nothing is queued; cores must keep addr/data stable until mready returns.

module mem_lane_sequencer #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mread,
    input  logic                        mwrite,
    input  logic [N_CORES-1:0]          en,
    input  logic [N_CORES*ADDR_W-1:0]   addr,
    input  logic [N_CORES*DATA_W-1:0]   data,
    output logic [N_CORES*DATA_W-1:0]   q,
    output logic [N_CORES-1:0]          q_valid,
    output logic                        mready,
    output logic                        done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    output logic                        mem_rden,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [1:0]                  dbg_state
);

    localparam int LANE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [N_CORES-1:0]  pend;
    logic [LANE_W-1:0]   lane;
    logic [31:0]         lane_ix;
    logic                op_wr;
    logic [2:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_hold;
    logic [DATA_W-1:0]   wdata_hold;
    logic [N_CORES-1:0]  lane_oh;
    logic [N_CORES-1:0]  pend_rest;
    logic                start;
    logic                capture;
    logic                lane_done;

    // Lowest set bit wins: the downward loop leaves the smallest index last.
    function automatic logic [LANE_W-1:0] lowest_lane(input logic [N_CORES-1:0] m);
        lowest_lane = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

    assign lane_ix   = 32'(lane);
    assign dbg_state = state;
    assign start     = ((state == S_IDLE) || (state == S_FINISH)) && (mread || mwrite);

    always_comb begin
        lane_oh       = '0;
        lane_oh[lane] = 1'b1;
    end

    // Mask left once the current lane is retired.
    assign pend_rest = pend & ~lane_oh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mready     = 1'b0;
        done       = 1'b0;
        mem_wren   = 1'b0;
        mem_rden   = 1'b0;
        mem_addr   = addr_hold;
        mem_wdata  = wdata_hold;
        capture    = 1'b0;
        lane_done  = 1'b0;
        case (state)
            S_IDLE: begin
                mready = 1'b1;
                if (start) state_next = (en == '0) ? S_FINISH : S_ACCESS;
            end
            S_ACCESS: begin
                mem_addr = addr[lane_ix*ADDR_W +: ADDR_W];
                if (op_wr) begin
                    mem_wren  = 1'b1;
                    mem_wdata = data[lane_ix*DATA_W +: DATA_W];
                    lane_done = 1'b1;
                end else begin
                    mem_rden = 1'b1;
                    if (RD_LAT == 0) begin
                        // Combinational memory: the result is already on mem_rdata.
                        capture   = 1'b1;
                        lane_done = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
                if (lane_done) state_next = (pend_rest == '0) ? S_FINISH : S_ACCESS;
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    capture    = 1'b1;
                    lane_done  = 1'b1;
                    state_next = (pend_rest == '0) ? S_FINISH : S_ACCESS;
                end
            end
            S_FINISH: begin
                mready = 1'b1;
                done   = 1'b1;
                if (start) state_next = (en == '0) ? S_FINISH : S_ACCESS;
                else       state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            lane       <= '0;
            op_wr      <= 1'b0;
            wait_cnt   <= 3'd0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            q          <= '0;
            q_valid    <= '0;
        end else begin
            if (start) begin
                pend    <= en;
                op_wr   <= mwrite;
                q_valid <= '0;
                lane    <= lowest_lane(en);
            end else if (lane_done) begin
                pend <= pend_rest;
                lane <= lowest_lane(pend_rest);
            end

            // Address/data are held so the memory sees stable values in WAIT.
            if (state == S_ACCESS) begin
                addr_hold <= mem_addr;
                if (op_wr) wdata_hold <= mem_wdata;
                else       wait_cnt   <= 3'(RD_LAT - 1);
            end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (capture) begin
                q[lane_ix*DATA_W +: DATA_W] <= mem_rdata;
                q_valid[lane]               <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// Testbench for mem_lane_sequencer: one instance with RD_LAT=1 driven from a
// cycle-by-cycle vector table plus a reset-abort sequence, and one instance
// with RD_LAT=0 for the combinational-read and ignored-request cases.

module tb_mem_lane_sequencer;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared stimulus ----------------
    logic [N-1:0]    en;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic            mem_init;

    // ---------------- DUT with RD_LAT=1 ----------------
    logic            mread1, mwrite1;
    logic [N*DW-1:0] q1;
    logic [N-1:0]    qv1;
    logic            rdy1, done1, wren1, rden1;
    logic [AW-1:0]   addr1;
    logic [DW-1:0]   wdata1, rdata1;
    logic [1:0]      st1;

    mem_lane_sequencer #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .mread(mread1), .mwrite(mwrite1), .en(en),
        .addr(addr), .data(data), .q(q1), .q_valid(qv1), .mready(rdy1), .done(done1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_wren(wren1), .mem_rden(rden1),
        .mem_rdata(rdata1), .dbg_state(st1)
    );

    // ---------------- DUT with RD_LAT=0 ----------------
    logic            mread0, mwrite0;
    logic [N*DW-1:0] q0;
    logic [N-1:0]    qv0;
    logic            rdy0, done0, wren0, rden0;
    logic [AW-1:0]   addr0;
    logic [DW-1:0]   wdata0, rdata0;
    logic [1:0]      st0;

    mem_lane_sequencer #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .mread(mread0), .mwrite(mwrite0), .en(en),
        .addr(addr), .data(data), .q(q0), .q_valid(qv0), .mready(rdy0), .done(done0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_wren(wren0), .mem_rden(rden0),
        .mem_rdata(rdata0), .dbg_state(st0)
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] mem1 [0:65535];
    logic [DW-1:0] mem0 [0:65535];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4; i++) begin
                mem1[16'(16'h10 + i)] <= 16'(16'hA0 + i);
                mem0[16'(16'h10 + i)] <= 16'(16'hA0 + i);
            end
        end else begin
            if (wren1) mem1[addr1] <= wdata1;
            if (rden1) rdata1 <= mem1[addr1];
            if (wren0) mem0[addr0] <= wdata0;
        end
    end
    assign rdata0 = mem0[addr0];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read and write enables must never be active together.
    always @(negedge clk) begin
        if (!reset && !mem_init) begin
            check("excl_dut1", {63'd0, wren1 & rden1}, 64'd0);
            check("excl_dut0", {63'd0, wren0 & rden0}, 64'd0);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  en;
        logic        e_rdy;
        logic        e_done;
        logic        e_rden;
        logic        e_wren;
        logic        c_addr;
        logic [15:0] e_addr;
        logic        c_wd;
        logic [15:0] e_wd;
        logic        c_q;
        logic [63:0] e_q;
        logic [3:0]  e_qv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] e,
                                input logic rdy, input logic dn, input logic rde, input logic wre,
                                input logic ca, input logic [15:0] a,
                                input logic cw, input logic [15:0] wd,
                                input logic cq, input logic [63:0] qq, input logic [3:0] qv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.en = e;
        v.e_rdy = rdy; v.e_done = dn; v.e_rden = rde; v.e_wren = wre;
        v.c_addr = ca; v.e_addr = a; v.c_wd = cw; v.e_wd = wd;
        v.c_q = cq; v.e_q = qq; v.e_qv = qv;
        return v;
    endfunction

    localparam logic [63:0] Q_T1 = 64'h00A3_0000_00A1_00A0;
    localparam logic [63:0] Q_T2 = 64'h00A3_5502_00A1_5500;

    // ---------------- driver ----------------
    initial begin
        logic got;
        int   busy, rd_cnt, wr_cnt, done_cyc;

        reset = 1'b1; mem_init = 1'b1;
        mread1 = 1'b0; mwrite1 = 1'b0; mread0 = 1'b0; mwrite0 = 1'b0;
        en = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = 16'(16'h10 + i);
            data[i*DW +: DW] = 16'(16'h5500 + i);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_mready", {63'd0, rdy1}, 64'd1);
        check("rst_done", {63'd0, done1}, 64'd0);
        check("rst_q", q1, 64'd0);
        check("rst_qv", {60'd0, qv1}, 64'd0);
        check("rst_addr", {48'd0, addr1}, 64'd0);
        check("rst_wdata", {48'd0, wdata1}, 64'd0);
        check("rst_en", {62'd0, wren1, rden1}, 64'd0);
        check("rst_mready0", {63'd0, rdy0}, 64'd1);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;

        // rd wr en   rdy dn rde wre  ca addr     cw wdata     cq q     qv
        // Read lanes 0,1,3; requests while busy are ignored.
        vecs.push_back(mk(1, 0, 4'b1011, 0, 0, 1, 0, 1, 16'h0010, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b1011, 0, 0, 0, 0, 1, 16'h0010, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1011, 0, 0, 1, 0, 1, 16'h0011, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(1, 1, 4'b1011, 0, 0, 0, 0, 1, 16'h0011, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b1011, 0, 0, 1, 0, 1, 16'h0013, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b1011, 0, 0, 0, 0, 1, 16'h0013, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b1011, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T1, 4'b1011));
        vecs.push_back(mk(0, 0, 4'b1011, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T1, 4'b1011));
        // Write lanes 0 and 2.
        vecs.push_back(mk(0, 1, 4'b0101, 0, 0, 0, 1, 1, 16'h0010, 1, 16'h5500, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 1, 1, 16'h0012, 1, 16'h5502, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T1, 4'b0000));
        // Read back lanes 0 and 2.
        vecs.push_back(mk(1, 0, 4'b0101, 0, 0, 1, 0, 1, 16'h0010, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 1, 16'h0010, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 1, 0, 1, 16'h0012, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 0, 1, 16'h0012, 0, 16'h0, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0101, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T2, 4'b0101));
        vecs.push_back(mk(0, 0, 4'b0101, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T2, 4'b0101));
        // Empty mask read: done in cycle 1, mready stays high.
        vecs.push_back(mk(1, 0, 4'b0000, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T2, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T2, 4'b0000));
        // mread and mwrite together: write wins.
        vecs.push_back(mk(1, 1, 4'b0001, 0, 0, 0, 1, 1, 16'h0010, 1, 16'h5500, 0, 64'd0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0001, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0, 1, Q_T2, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0, 0, 64'd0, 4'b0000));

        foreach (vecs[k]) begin
            @(negedge clk);
            mread1 = vecs[k].rd; mwrite1 = vecs[k].wr; en = vecs[k].en;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mready", k), {63'd0, rdy1}, {63'd0, vecs[k].e_rdy});
            check($sformatf("v%0d_done", k), {63'd0, done1}, {63'd0, vecs[k].e_done});
            check($sformatf("v%0d_rden", k), {63'd0, rden1}, {63'd0, vecs[k].e_rden});
            check($sformatf("v%0d_wren", k), {63'd0, wren1}, {63'd0, vecs[k].e_wren});
            if (vecs[k].c_addr) check($sformatf("v%0d_addr", k), {48'd0, addr1}, {48'd0, vecs[k].e_addr});
            if (vecs[k].c_wd)   check($sformatf("v%0d_wdata", k), {48'd0, wdata1}, {48'd0, vecs[k].e_wd});
            if (vecs[k].c_q) begin
                check($sformatf("v%0d_q", k), q1, vecs[k].e_q);
                check($sformatf("v%0d_qv", k), {60'd0, qv1}, {60'd0, vecs[k].e_qv});
            end
        end
        @(negedge clk);
        mread1 = 1'b0; mwrite1 = 1'b0;

        // ---- reset while waiting on lane 1's read ----
        @(negedge clk);
        en = 4'b0010; mread1 = 1'b1;
        @(posedge clk); #1;
        check("ab_access_addr", {48'd0, addr1}, 64'h11);
        check("ab_access_rden", {63'd0, rden1}, 64'd1);
        @(negedge clk);
        mread1 = 1'b0;
        @(posedge clk); #1;
        check("ab_wait_mready", {63'd0, rdy1}, 64'd0);
        #2 reset = 1'b1;
        #1;
        check("ab_rst_mready", {63'd0, rdy1}, 64'd1);
        check("ab_rst_done", {63'd0, done1}, 64'd0);
        check("ab_rst_q", q1, 64'd0);
        check("ab_rst_qv", {60'd0, qv1}, 64'd0);
        check("ab_rst_addr", {48'd0, addr1}, 64'd0);
        check("ab_rst_rden", {63'd0, rden1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("ab_nodone_%0d", c), {63'd0, done1}, 64'd0);
            check($sformatf("ab_idle_%0d", c), {63'd0, rdy1}, 64'd1);
        end
        @(negedge clk);
        en = 4'b0010; mread1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        mread1 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done1) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("ab_rerun_done_seen", {63'd0, got}, 64'd1);
        check("ab_rerun_q", q1, 64'h0000_0000_00A1_0000);
        check("ab_rerun_qv", {60'd0, qv1}, 64'h2);

        // ---- RD_LAT=0 instance: four lanes, mwrite pulsed while busy ----
        @(negedge clk);
        en = 4'b1111; mread0 = 1'b1;
        @(posedge clk); #1;
        busy = 0; rd_cnt = 0; wr_cnt = 0; done_cyc = 0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (!rdy0) busy++;
            if (rden0) rd_cnt++;
            if (wren0) wr_cnt++;
            if (done0) begin
                got = 1'b1;
                done_cyc = c;
            end
            @(negedge clk);
            mread0  = 1'b0;
            mwrite0 = (c == 2);
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check("z_done_seen", {63'd0, got}, 64'd1);
        check("z_done_cycle", 64'(done_cyc), 64'd5);
        check("z_busy_cycles", 64'(busy), 64'd4);
        check("z_reads", 64'(rd_cnt), 64'd4);
        check("z_writes", 64'(wr_cnt), 64'd0);
        check("z_q", q0, 64'h00A3_00A2_00A1_00A0);
        check("z_qv", {60'd0, qv0}, 64'hF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check($sformatf("z_idle_wren_%0d", c), {63'd0, wren0}, 64'd0);
            check($sformatf("z_idle_mready_%0d", c), {63'd0, rdy0}, 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
